// File: rtl/fir_filter_param_if.sv
// Sample/coefficient request and filtered-result bus for fir_filter_param.
interface fir_filter_param_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic signed [DATA_W-1:0] sample_data;
  logic                     data_ready;
  logic signed [DATA_W-1:0] fir_coefficient;
  logic                     load_coeff;
  logic                     modwait;
  logic        [DATA_W-1:0] fir_out;
  logic                     out_valid;
  logic                     one_k_samples;
  logic                     err;

  // Source side: drives samples/coefficients, observes results
  modport master (
    output sample_data, data_ready, fir_coefficient, load_coeff,
    input  modwait, fir_out, out_valid, one_k_samples, err
  );

  // Filter side
  modport slave (
    input  sample_data, data_ready, fir_coefficient, load_coeff,
    output modwait, fir_out, out_valid, one_k_samples, err
  );
endinterface

// File: rtl/fir_filter_param.sv
// NTAPS-tap signed FIR: sequential coefficient load, one MAC per cycle,
// saturated magnitude output and a programmable output counter.
module fir_filter_param #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NTAPS     = 4,
  parameter int unsigned CNT_LIMIT = 1000
) (
  input logic               clk,
  input logic               n_reset,
  fir_filter_param_if.slave bus
);

  localparam int unsigned DW = DATA_W;
  localparam int unsigned IW = $clog2(NTAPS);
  localparam int unsigned AW = 2 * DW + $clog2(NTAPS);
  localparam int unsigned CW = $clog2(CNT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [DW-1:0]   x_q     [NTAPS];
  logic signed [DW-1:0]   x_d     [NTAPS];
  logic signed [DW-1:0]   coeff_q [NTAPS];
  logic signed [DW-1:0]   coeff_d [NTAPS];
  logic        [IW-1:0]   ptr_q, ptr_d;
  logic        [IW-1:0]   idx_q, idx_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic        [CW-1:0]   cnt_q, cnt_d;
  logic                   dr_q, lc_q;
  logic                   modwait_q, modwait_d;
  logic        [DW-1:0]   fir_out_q, fir_out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   one_k_q, one_k_d;
  logic                   err_q, err_d;

  logic                   dr_rise_c, lc_rise_c;
  logic signed [2*DW-1:0] prod_c;
  logic signed [AW-1:0]   y_c;
  logic signed [AW:0]     y_ext_c;
  logic        [AW:0]     mag_c;
  logic                   sat_c;
  logic        [CW-1:0]   cnt_inc_c;

  // Rising-edge requests; a held level is a single request
  assign dr_rise_c = bus.data_ready & ~dr_q;
  assign lc_rise_c = bus.load_coeff & ~lc_q;

  // Current tap product and scaled, saturated magnitude of the accumulator
  assign prod_c    = x_q[idx_q] * coeff_q[idx_q];
  assign y_c       = acc_q >>> (DW - 1);
  assign y_ext_c   = (AW + 1)'(y_c);
  assign mag_c     = y_ext_c[AW] ? (AW + 1)'(-y_ext_c) : (AW + 1)'(y_ext_c);
  assign sat_c     = |mag_c[AW:DW];
  assign cnt_inc_c = cnt_q + CW'(1);

  // State register and datapath registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < int'(NTAPS); i++) begin
        x_q[i]     <= '0;
        coeff_q[i] <= '0;
      end
      ptr_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dr_q        <= 1'b0;
      lc_q        <= 1'b0;
      modwait_q   <= 1'b0;
      fir_out_q   <= '0;
      out_valid_q <= 1'b0;
      one_k_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      coeff_q     <= coeff_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dr_q        <= bus.data_ready;
      lc_q        <= bus.load_coeff;
      modwait_q   <= modwait_d;
      fir_out_q   <= fir_out_d;
      out_valid_q <= out_valid_d;
      one_k_q     <= one_k_d;
      err_q       <= err_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    coeff_d     = coeff_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    fir_out_d   = fir_out_q;
    out_valid_d = 1'b0;
    one_k_d     = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        // modwait lingers one cycle after DONE; requests then are still dropped
        if (modwait_q) begin
          if (dr_rise_c || lc_rise_c) err_d = 1'b1;
        end else if (lc_rise_c) begin
          state_d = LOAD;
          if (dr_rise_c) err_d = 1'b1;
        end else if (dr_rise_c) begin
          state_d = MAC;
          x_d[0]  = bus.sample_data;
          for (int i = 1; i < int'(NTAPS); i++) x_d[i] = x_q[i-1];
          acc_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        coeff_d[ptr_q] = bus.fir_coefficient;
        ptr_d          = (ptr_q == IW'(NTAPS - 1)) ? IW'(0) : ptr_q + IW'(1);
        if (ptr_q == IW'(0)) cnt_d = '0;
        if (dr_rise_c || lc_rise_c) err_d = 1'b1;
        state_d        = IDLE;
      end
      MAC: begin
        acc_d = acc_q + AW'(prod_c);
        if (idx_q == IW'(NTAPS - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
        if (dr_rise_c || lc_rise_c) err_d = 1'b1;
      end
      DONE: begin
        fir_out_d   = sat_c ? '1 : mag_c[DW-1:0];
        err_d       = err_q | sat_c | dr_rise_c | lc_rise_c;
        out_valid_d = 1'b1;
        if (cnt_inc_c == CW'(CNT_LIMIT)) begin
          cnt_d   = '0;
          one_k_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    modwait_d = (state_d != IDLE) || (state_q == DONE);
  end

  assign bus.modwait       = modwait_q;
  assign bus.fir_out       = fir_out_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.one_k_samples = one_k_q;
  assign bus.err           = err_q;

endmodule
